mcu_addr_chan: RTL
==================

// Module: mcu_addr_chan
// PURPOSE
//  Parametrised MCU address-pointer unit, successor to the single-pointer decode in the MCU command block.
//  Holds NUM_CH independent address pointers, each with its own wrap mask, loaded from SPI parameter bytes.
//  Pointers auto-increment on MCU read/write completions and on SD-DMA nextaddr pulses.
//  Adds request tracking with overrun and timeout detection; sits between SPI command decode and memory arbiter.
// PARAMETERS
//  NUM_CH   4    number of address channels, 1..8
//  AW       24   address width per channel, 8..32
//  TIMEOUT  255  max cycles a request may wait for mcu_rq_rdy before it is dropped, >=2
// PORTS
//  clk           in   1          system clock
//  rst           in   1          synchronous reset, active high
//  cmd_ready     in   1          1-cycle strobe: cmd_data holds new command byte
//  param_ready   in   1          1-cycle strobe: param_data holds new parameter byte
//  cmd_data      in   8          current command; [2:0] = channel index c
//  param_data    in   8          current parameter byte
//  spi_byte_cnt  in   32         byte index in transaction; command byte = 1
//  dma_nextaddr  in   1          SD-DMA increment strobe
//  dma_tgt       in   3          channel incremented by dma_nextaddr
//  mcu_rq_rdy    in   1          arbiter ready level; rising edge = request done
//  mcu_rrq       out  1          1-cycle read request pulse
//  mcu_wrq       out  1          1-cycle write request pulse
//  mcu_ch        out  3          channel of the outstanding/last request
//  addr_out      out  NUM_CH*AW  channel c at [c*AW +: AW]
//  err_flags     out  2          sticky: [0] overrun, [1] timeout
// BEHAVIOUR
//  Reset: all pointers 0, all masks all-ones, mcu_rrq=mcu_wrq=0, mcu_ch=0, err_flags=0, FSM IDLE, edge reg 0.
//  Commands, decoded on cmd_data[7:3] with c=cmd_data[2:0]; c>=NUM_CH ignored entirely, no flags raised:
//   0x00|c  load pointer c: NB=ceil(AW/8) bytes, big-endian, at byte_cnt 2..NB+1; byte_cnt 2 also zeroes
//           the lower bits; bits above AW are discarded; bytes beyond NB are ignored.
//   0x10|c  load mask c, same byte format as 0x00.
//   0x80|c  read stream: every cmd_ready or param_ready in this command issues a read request on c.
//   0x90|c  write stream: every param_ready in this command issues a write request on c.
//   0xE5    on cmd_ready, clear err_flags.
//  Increment rule: new = (p & ~m) | ((p+1) & m), i.e. wraps within the mask bits, upper bits frozen.
//  Request FSM: IDLE -> REQ on strobe; REQ drives the rrq/wrq pulse for exactly 1 cycle (cycle after
//   strobe) and latches mcu_ch=c -> WAIT; WAIT -> IDLE on mcu_rq_rdy rising edge (registered prev sample),
//   incrementing pointer mcu_ch in the same cycle; WAIT -> IDLE after TIMEOUT cycles, no increment, sets err[1].
//  A strobe while in REQ/WAIT: request dropped, err[0] set, FSM unaffected.
//  dma_nextaddr increments dma_tgt (ignored if >=NUM_CH); pointer updates appear the cycle after the strobe/edge.
//  Simultaneous DMA and MCU increment on one channel: +2 with the wrap rule applied twice. Different
//   channels: both update.
//  Load and increment on the same channel and cycle: load wins, increment lost.
//  rst mid-request: FSM to IDLE, no pulse, no increment.
// TESTING
//  Load ch1 via 0x01,12,34,56 -> addr_out[47:24]=0x123456; other channels unchanged.
//  Mask ch0=0x0000FF, ptr=0xAB00FF, 0x80 cmd + rq_rdy edge -> ptr=0xAB0000; err=0.
//  0x91, 3 params, rq_rdy rising 4 cycles after each wrq -> 3 wrq pulses, ch1 ptr +3.
//  Two params 1 cycle apart on 0x90 -> single wrq, err_flags=01; 0xE5 -> err_flags=00.
//  0x82 with rq_rdy held low -> after TIMEOUT cycles FSM idle, err_flags=10, ptr2 unchanged.
//  dma_tgt=0 strobe same cycle as MCU completion on ch0 (ptr=5) -> ptr=7; cmd 0x07 with NUM_CH=4 -> no effect.

Source files
------------

// File: rtl/mcu_addr_chan_if.sv
// Bundle of the SPI command/parameter, SD-DMA and arbiter signals around the
// MCU address-pointer unit.
//   master : drives the command/parameter strobes, DMA strobe and arbiter ready;
//            observes the request pulses, request channel, pointers and flags.
//   slave  : the address-pointer unit itself.
interface mcu_addr_chan_if #(
  parameter int NUM_CH = 4,
  parameter int AW     = 24
) ();
  logic                 cmd_ready;
  logic                 param_ready;
  logic [7:0]           cmd_data;
  logic [7:0]           param_data;
  logic [31:0]          spi_byte_cnt;
  logic                 dma_nextaddr;
  logic [2:0]           dma_tgt;
  logic                 mcu_rq_rdy;
  logic                 mcu_rrq;
  logic                 mcu_wrq;
  logic [2:0]           mcu_ch;
  logic [NUM_CH*AW-1:0] addr_out;
  logic [1:0]           err_flags;

  modport master (
    output cmd_ready, param_ready, cmd_data, param_data, spi_byte_cnt,
           dma_nextaddr, dma_tgt, mcu_rq_rdy,
    input  mcu_rrq, mcu_wrq, mcu_ch, addr_out, err_flags
  );

  modport slave (
    input  cmd_ready, param_ready, cmd_data, param_data, spi_byte_cnt,
           dma_nextaddr, dma_tgt, mcu_rq_rdy,
    output mcu_rrq, mcu_wrq, mcu_ch, addr_out, err_flags
  );
endinterface

// File: rtl/mcu_addr_chan.sv
// MCU address-pointer unit.
// Holds NUM_CH address pointers, each with its own wrap mask, loaded from SPI
// parameter bytes. Pointers auto-increment on completed MCU read/write
// requests and on SD-DMA nextaddr strobes. A small request FSM issues one
// rrq/wrq pulse per stream strobe, waits for the arbiter's ready rising edge,
// and flags overruns (strobe while busy) and timeouts (no ready in time).
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active high
//   bus  : mcu_addr_chan_if.slave (SPI decode, DMA strobe, arbiter handshake,
//          flattened pointers addr_out, sticky err_flags {timeout, overrun})
module mcu_addr_chan #(
  parameter int NUM_CH  = 4,
  parameter int AW      = 24,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  mcu_addr_chan_if.slave  bus
);

  localparam int NB = (AW + 7) / 8;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [4:0] OP_LDP = 5'h00;
  localparam logic [4:0] OP_LDM = 5'h02;
  localparam logic [4:0] OP_RD  = 5'h10;
  localparam logic [4:0] OP_WR  = 5'h12;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   ptr     [NUM_CH];
  logic [AW-1:0]   msk     [NUM_CH];
  logic [AW-1:0]   ptr_nxt [NUM_CH];
  logic [AW-1:0]   msk_nxt [NUM_CH];
  logic [2:0]      ch_q;
  logic            req_wr;
  logic [TW-1:0]   tmo_cnt;
  logic [1:0]      err;
  logic            rdy_p1;

  logic [4:0]      op;
  logic [2:0]      cmd_ch;
  logic            ch_ok;
  logic            in_load;
  logic            ld_ptr, ld_msk;
  logic            rd_strobe, wr_strobe, strobe;
  logic            rdy_rise;
  logic            dma_inc;
  logic            mcu_inc;
  logic            take;
  logic            tmo_hit;
  logic            ovr;
  logic            err_clr;
  logic [NUM_CH*AW-1:0] addr_flat;

  // Increment that wraps inside the mask bits; bits outside the mask hold.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p,
                                             input logic [AW-1:0] m);
    return (p & ~m) | ((p + AW'(1)) & m);
  endfunction

  // Big-endian byte shift-in; the first byte clears whatever was there so a
  // short load never leaves stale upper bits, and overflow above AW drops.
  function automatic logic [AW-1:0] shift_byte(input logic [AW-1:0] old,
                                               input logic [7:0]    b,
                                               input logic          first);
    logic [AW+7:0] cat;
    cat = first ? {{AW{1'b0}}, b} : {old, b};
    return cat[AW-1:0];
  endfunction

  // Command decode
  assign op       = bus.cmd_data[7:3];
  assign cmd_ch   = bus.cmd_data[2:0];
  assign ch_ok    = ({1'b0, cmd_ch} < 4'(NUM_CH));
  assign in_load  = (bus.spi_byte_cnt >= 32'd2) && (bus.spi_byte_cnt <= 32'(NB + 1));
  assign ld_ptr   = bus.param_ready && ch_ok && (op == OP_LDP) && in_load;
  assign ld_msk   = bus.param_ready && ch_ok && (op == OP_LDM) && in_load;
  assign rd_strobe = ch_ok && (op == OP_RD) && (bus.cmd_ready || bus.param_ready);
  assign wr_strobe = ch_ok && (op == OP_WR) && bus.param_ready;
  assign strobe    = rd_strobe || wr_strobe;
  assign err_clr   = bus.cmd_ready && (bus.cmd_data == 8'hE5);

  assign rdy_rise = bus.mcu_rq_rdy && !rdy_p1;
  assign dma_inc  = bus.dma_nextaddr && ({1'b0, bus.dma_tgt} < 4'(NUM_CH));

  // Request FSM: next state and control strobes
  always_comb begin
    state_nxt = state;
    mcu_inc   = 1'b0;
    tmo_hit   = 1'b0;
    take      = 1'b0;
    ovr       = 1'b0;
    case (state)
      S_IDLE: begin
        if (strobe) begin
          state_nxt = S_REQ;
          take      = 1'b1;
        end
      end
      S_REQ: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rdy_rise) begin
          state_nxt = S_IDLE;
          mcu_inc   = 1'b1;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt = S_IDLE;
          tmo_hit   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (strobe && (state != S_IDLE)) ovr = 1'b1;
  end

  // Per-channel pointer/mask next values; a load on the channel overrides
  // any increment in the same cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ptr_nxt[c] = ptr[c];
      msk_nxt[c] = msk[c];
      if (mcu_inc && (ch_q == 3'(c)))
        ptr_nxt[c] = wrap_inc(ptr_nxt[c], msk[c]);
      if (dma_inc && (bus.dma_tgt == 3'(c)))
        ptr_nxt[c] = wrap_inc(ptr_nxt[c], msk[c]);
      if (ld_ptr && (cmd_ch == 3'(c)))
        ptr_nxt[c] = shift_byte(ptr[c], bus.param_data, bus.spi_byte_cnt == 32'd2);
      if (ld_msk && (cmd_ch == 3'(c)))
        msk_nxt[c] = shift_byte(msk[c], bus.param_data, bus.spi_byte_cnt == 32'd2);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ch_q    <= 3'd0;
      req_wr  <= 1'b0;
      tmo_cnt <= '0;
      err     <= 2'b00;
      rdy_p1  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        ptr[c] <= '0;
        msk[c] <= '1;
      end
    end else begin
      state  <= state_nxt;
      rdy_p1 <= bus.mcu_rq_rdy;
      if (take) begin
        ch_q   <= cmd_ch;
        req_wr <= wr_strobe;
      end
      tmo_cnt <= (state == S_WAIT) ? tmo_cnt + TW'(1) : '0;
      err     <= (err_clr ? 2'b00 : err) | {tmo_hit, ovr};
      for (int c = 0; c < NUM_CH; c++) begin
        ptr[c] <= ptr_nxt[c];
        msk[c] <= msk_nxt[c];
      end
    end
  end

  // Outputs
  always_comb begin
    addr_flat = '0;
    for (int c = 0; c < NUM_CH; c++)
      addr_flat[c*AW +: AW] = ptr[c];
  end

  assign bus.addr_out  = addr_flat;
  assign bus.mcu_rrq   = (state == S_REQ) && !req_wr;
  assign bus.mcu_wrq   = (state == S_REQ) && req_wr;
  assign bus.mcu_ch    = ch_q;
  assign bus.err_flags = err;

endmodule
